neuron_mac_seq: RTL

- Sequential fixed-point neuron pre-activation engine.
- Serially accumulates NUM_TERMS input×weight products plus a bias into a guarded Q(QM+N).QN sum.
- Presents the sum over a valid/ready handshake; the output is the direct producer for the Sigmoid activation input (same width and Q format).
- One multiply-accumulate per cycle, one neuron at a time.

---
 rtl/nn_fixed_pkg.sv | 51 +++++
 rtl/fx_mul_rescale.sv | 23 ++
 rtl/neuron_mac_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the neuron datapath.
//   QM/QN/N  : integer bits, fractional bits, accumulator guard bits
//   DATA_W   : width of x, w and bias (Q(QM).(QN))
//   ACC_W    : accumulator / pre-activation width (Q(QM+N).(QN))
//   PROD_W   : full-precision product width
//   state_t  : sequencing states of the serial MAC engine
//   sat_add  : full-width add with clamp to a signed range of a given width
package nn_fixed_pkg;

    localparam int unsigned QM     = 6;
    localparam int unsigned QN     = 10;
    localparam int unsigned N      = 2;
    localparam int unsigned DATA_W = QM + QN;
    localparam int unsigned ACC_W  = QM + QN + N;
    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operands arrive sign-extended to 64 bits so the sum cannot wrap; the
    // result is clamped to the signed range of an acc_w-bit accumulator.
    function automatic logic signed [63:0] sat_add(
        input  logic signed [63:0] a,
        input  logic signed [63:0] b,
        input  int unsigned        acc_w,
        output logic               sat
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        sat = 1'b0;
        sat_add = sum;
        if (sum > hi) begin
            sat_add = hi;
            sat     = 1'b1;
        end else if (sum < lo) begin
            sat_add = lo;
            sat     = 1'b1;
        end
    endfunction

endpackage

// File: rtl/fx_mul_rescale.sv
// Combinational signed fixed-point multiply with rescale back to QN fraction.
//   x, w   : signed Q.QN operands (DATA_W bits)
//   prod_c : (x*w) >>> QN, floor-rounded, 2*DATA_W-QN bits (never overflows)
module fx_mul_rescale #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned QN     = 10
) (
    input  logic [DATA_W-1:0]          x,
    input  logic [DATA_W-1:0]          w,
    output logic [2*DATA_W-QN-1:0]     prod_c
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] full_c;
    logic signed [PROD_W-1:0] shifted_c;

    assign full_c    = PROD_W'($signed(x)) * PROD_W'($signed(w));
    // Arithmetic shift drops the low fraction bits: rounds toward -inf.
    assign shifted_c = full_c >>> QN;
    assign prod_c    = shifted_c[PROD_W-QN-1:0];

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron pre-activation engine: bias + sum of NUM_TERMS x*w
// products, one MAC per cycle, saturating into a Q(QM+N).QN accumulator.
//   clk, rst             : clock, synchronous active-high reset
//   start, bias          : launch a neuron (IDLE only), bias captured with it
//   in_valid/in_ready    : x/w pair handshake
//   x, w                 : signed QM.QN activation and weight
//   out_valid/out_ready  : result handshake toward the activation stage
//   out_sum, out_sat     : pre-activation sum and sticky saturation flag
module neuron_mac_seq
    import nn_fixed_pkg::state_t, nn_fixed_pkg::IDLE, nn_fixed_pkg::ACCUM,
           nn_fixed_pkg::DONE, nn_fixed_pkg::sat_add;
#(
    parameter int unsigned N         = nn_fixed_pkg::N,
    parameter int unsigned QM        = nn_fixed_pkg::QM,
    parameter int unsigned QN        = nn_fixed_pkg::QN,
    parameter int unsigned NUM_TERMS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [QM+QN-1:0]     bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QM+QN-1:0]     x,
    input  logic [QM+QN-1:0]     w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QM+QN+N-1:0]   out_sum,
    output logic                 out_sat
);

    localparam int unsigned DATA_W = QM + QN;
    localparam int unsigned ACC_W  = QM + QN + N;
    localparam int unsigned RES_W  = 2 * DATA_W - QN;
    localparam int unsigned CNT_W  = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               clamp_c;
    logic [RES_W-1:0]   prod_c;

    // Rescaled product of the pair currently presented.
    fx_mul_rescale #(
        .DATA_W (DATA_W),
        .QN     (QN)
    ) u_mul (
        .x      (x),
        .w      (w),
        .prod_c (prod_c)
    );

    // Next-state, datapath and handshake-flag logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        clamp_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = {{N{bias[DATA_W-1]}}, bias};
                    count_d = '0;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // in_ready is high for the whole of ACCUM, so in_valid alone
                // completes the handshake here.
                if (in_valid) begin
                    acc_d   = ACC_W'(sat_add(64'($signed(acc_q)), 64'($signed(prod_c)),
                                             ACC_W, clamp_c));
                    sat_d   = sat_q | clamp_c;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;

endmodule
